// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer around a 1-bit full adder (addbit): feeds operand bits
// LSB first with a registered carry, collects sum/carry and assembles the WIDTH-bit result.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_sum,
    input  logic             add_co
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_out_q, carry_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        r_sh_d      = r_sh_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        carry_out_d = carry_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = op_a;
                    b_sh_d  = op_b;
                    r_sh_d  = '0;
                    cy_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Shifting in zeros leaves a_sh/b_sh empty after WIDTH edges, so add_a/add_b idle at 0.
                a_sh_d              = a_sh_q >> 1;
                b_sh_d              = b_sh_q >> 1;
                r_sh_d              = r_sh_q >> 1;
                r_sh_d[WIDTH-1]     = add_sum;
                cy_d                = add_co;
                cnt_d               = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    cy_d        = 1'b0;
                    result_d    = r_sh_d;
                    carry_out_d = add_co;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            r_sh_q      <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            cy_q        <= 1'b0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            r_sh_q      <= r_sh_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            cy_q        <= cy_d;
            carry_out_q <= carry_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign add_a     = a_sh_q[0];
    assign add_b     = b_sh_q[0];
    assign add_ci    = cy_q;

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
Bit-serial adder sequencer that sits directly upstream and downstream of the gate-level 1-bit full adder `addbit`.
- Accepts two WIDTH-bit operands on a start pulse.
- Presents one operand bit pair per clock, LSB first, plus a registered carry to addbit's a/b/ci inputs.
- Captures addbit's sum/co each clock and assembles the WIDTH-bit result and final carry.
- Replaces hand-written bench stimulus with a reusable multi-bit driver/collector around addbit.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clock      input   1      single system clock, rising-edge active
reset_n    input   1      asynchronous active-low reset
start      input   1      request; sampled only in IDLE
op_a       input   WIDTH  operand A, captured on accepted start
op_b       input   WIDTH  operand B, captured on accepted start
busy       output  1      high from accepted start through the DONE cycle
done       output  1      one-cycle pulse; result and carry_out valid
result     output  WIDTH  sum bits, held until the next accepted start
carry_out  output  1      final carry, held with result
add_a      output  1      to addbit a
add_b      output  1      to addbit b
add_ci     output  1      to addbit ci
add_sum    input   1      from addbit sum
add_co     input   1      from addbit co

Behaviour:
- Reset: one clock domain, `clock`; `reset_n` asynchronous, active-low. On assertion, immediately:
  - state=IDLE.
  - busy, done, result, carry_out, add_a, add_b, add_ci = 0.
  - Internal shift registers, carry register and bit counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - add_a/add_b/add_ci driven 0.
  - start=1 at a rising edge: load a_sh<=op_a, b_sh<=op_b, cy<=0, cnt<=0, busy<=1, go to RUN.
- RUN:
  - add_a=a_sh[0], add_b=b_sh[0], add_ci=cy. These are registered outputs; they are stable for the whole cycle.
  - At each rising edge: sample add_sum into r_sh MSB with r_sh shifting right, cy<=add_co, shift a_sh and b_sh right, cnt<=cnt+1.
  - After the edge where cnt==WIDTH-1: result<=final r_sh (bit 0 = first sampled sum), carry_out<=add_co, go to DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle; add_* driven 0.
  - Next edge goes to IDLE; done and busy drop to 0.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance. Throughput is one operation per WIDTH+2 cycles.
- Settling: addbit has up to 4 ns gate delay on sum/co. The clock period must exceed 4 ns; the sim bench uses 10 ns.
- Arithmetic: {carry_out, result} = op_a + op_b, unsigned, computed over WIDTH+1 bits. No overflow flag beyond carry_out.
- start while busy (RUN or DONE): ignored. No queuing, no effect on the operation in flight.
- op_a/op_b changes after acceptance: no effect.
- result/carry_out keep the last value through IDLE. They are only overwritten in the cycle done asserts.
- reset_n asserted mid-RUN or DONE: operation aborted, all outputs cleared, no done pulse.
- WIDTH=1: RUN lasts one cycle; otherwise identical behaviour.
- cnt width is clog2(WIDTH)+1. The counter never wraps in legal use.

Test Plan:
- WIDTH=8, op_a=0x03, op_b=0x05, start for 1 cycle → busy for 9 cycles, then done pulse; result=0x08, carry_out=0. add_a sequence, LSB first, is 1,1,0,0,0,0,0,0.
- WIDTH=8, 0xFF+0x01 → result=0x00, carry_out=1. add_ci sequence is 0,1,1,1,1,1,1,1.
- WIDTH=8, 0xFF+0xFF then 0xA5+0x5A back-to-back, start held high continuously → first: 0xFE, carry_out=1. Second accepted only in the IDLE cycle after DONE: 0xFF, carry_out=0. Exactly two done pulses.
- WIDTH=8, start 0x10+0x20, then start re-pulsed with 0x7F+0x7F in RUN cycle 3 → ignored; result=0x30, carry_out=0.
- WIDTH=8, start 0x81+0x81, assert reset_n low in RUN cycle 4 (mid-cycle, asynchronous) → busy/add_*/result drop to 0 immediately, no done. After release, 0x81+0x81 completes to result=0x02, carry_out=1.
- WIDTH=1 build, exhaustive 0+0, 0+1, 1+0, 1+1 → {carry_out,result} = 00, 01, 01, 10. done arrives 2 cycles after each accepted start.
